// File: rtl/udma_qspi_cmd_arb.sv
// udma_qspi_cmd_arb: packet-level round-robin arbiter sharing the uDMA QSPI command stream
// Ports: sys_clk_i/rst_i clock and async active-high reset; req_valid_i/req_data_i/req_last_i/req_ready_o
// per-requester command words; cmd_valid_o/cmd_data_o/cmd_ready_i shared command channel to the SPI master;
// spi_eot_i end-of-transfer pulse in; req_eot_o EOT routed to the owner; timeout_o watchdog pulse;
// busy_o high outside IDLE; owner_o current or last granted requester.
module udma_qspi_cmd_arb #(
  parameter int NB_REQ = 4,
  parameter int DATA_W = 32,
  parameter int EOT_TIMEOUT = 4096,
  localparam int IDW = $clog2(NB_REQ)
) (
  input  logic                     sys_clk_i,
  input  logic                     rst_i,
  input  logic [NB_REQ-1:0]        req_valid_i,
  input  logic [NB_REQ*DATA_W-1:0] req_data_i,
  input  logic [NB_REQ-1:0]        req_last_i,
  output logic [NB_REQ-1:0]        req_ready_o,
  output logic                     cmd_valid_o,
  output logic [DATA_W-1:0]        cmd_data_o,
  input  logic                     cmd_ready_i,
  input  logic                     spi_eot_i,
  output logic [NB_REQ-1:0]        req_eot_o,
  output logic                     timeout_o,
  output logic                     busy_o,
  output logic [IDW-1:0]           owner_o
);
  localparam int TW = EOT_TIMEOUT > 0 ? $clog2(EOT_TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, XFER, WAIT_EOT} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d, rr_q, rr_d, gnt, c;
  logic [TW-1:0] timer_q, timer_d;
  logic [NB_REQ-1:0] eot_q, eot_d;
  logic to_q, to_d, hs, expire;
  logic [DATA_W-1:0] words [NB_REQ];
  for (genvar i = 0; i < NB_REQ; i++) begin : g_w
    assign words[i] = req_data_i[i*DATA_W +: DATA_W];
  end
  assign cmd_valid_o = (state_q == XFER) && req_valid_i[owner_q];
  assign cmd_data_o  = cmd_valid_o ? words[owner_q] : '0;
  assign req_ready_o = (state_q == XFER) ? NB_REQ'(cmd_ready_i) << owner_q : '0;
  assign hs          = cmd_valid_o & cmd_ready_i;
  assign expire      = (EOT_TIMEOUT != 0) && (timer_q == TW'(EOT_TIMEOUT - 1));
  assign busy_o      = state_q != IDLE;
  assign owner_o     = owner_q;
  assign req_eot_o   = eot_q;
  assign timeout_o   = to_q;
  // scan downwards so the candidate closest after rr_q is the one left standing
  always_comb begin
    gnt = rr_q;
    c = '0;
    for (int k = NB_REQ - 1; k >= 0; k--) begin
      c = IDW'((int'(rr_q) + 1 + k) % NB_REQ);
      if (req_valid_i[c]) gnt = c;
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    timer_d = timer_q;
    eot_d   = '0;
    to_d    = 1'b0;
    case (state_q)
      IDLE: if (|req_valid_i) begin
        owner_d = gnt;
        rr_d    = gnt;
        state_d = XFER;
      end
      XFER: if (hs && req_last_i[owner_q]) begin
        state_d = WAIT_EOT;
        timer_d = '0;
      end
      WAIT_EOT: begin
        timer_d = timer_q + TW'(timer_q != '1);
        if (spi_eot_i) begin
          eot_d   = NB_REQ'(1) << owner_q;
          state_d = IDLE;
        end else if (expire) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= IDW'(NB_REQ - 1);
      timer_q <= '0;
      eot_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
      eot_q   <= eot_d;
      to_q    <= to_d;
    end
  end
endmodule
